// File: rtl/mc_sequencer.sv
// mc_sequencer: missionaries-and-cannibals river crossing with a built-in
// 11-move solution (AUTO) and validated manual boat loads (IDLE).
module mc_sequencer #(
    parameter int STEP_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       step_valid,
    input  logic [1:0] step_m,
    input  logic [1:0] step_c,
    output logic       step_ready,
    output logic [1:0] missionary_left,
    output logic [1:0] cannibal_left,
    output logic       direction,
    output logic [4:0] move_cnt,
    output logic       busy,
    output logic       done,
    output logic       illegal
);
    typedef enum logic [1:0] {IDLE, AUTO, DONE} state_t;

    // Solution loads as {missionaries, cannibals}, move 0 in the low nibble.
    localparam logic [43:0] TABLE = 44'h21218581212;

    state_t     state_q, state_d;
    logic [1:0] m_q, m_d, c_q, c_d;
    logic       dir_q, dir_d, ill_q, ill_d, busy_q, done_q;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d, pace_q, pace_d;

    logic [3:0] tab;
    logic [1:0] lm, lc, dm, dc, nm, nc, rm, rc;
    logic [2:0] sum;
    logic       legal, accept, wrap, go_home, apply;

    assign tab    = TABLE[{idx_q, 2'b00} +: 4];
    assign lm     = (state_q == AUTO) ? tab[3:2] : step_m;
    assign lc     = (state_q == AUTO) ? tab[1:0] : step_c;
    assign sum    = {1'b0, lm} + {1'b0, lc};
    assign dm     = dir_q ? 2'd3 - m_q : m_q;
    assign dc     = dir_q ? 2'd3 - c_q : c_q;
    assign nm     = dir_q ? m_q + lm : m_q - lm;
    assign nc     = dir_q ? c_q + lc : c_q - lc;
    assign rm     = 2'd3 - nm;
    assign rc     = 2'd3 - nc;
    assign legal  = (sum != 3'd0) && (sum <= 3'd2) && (dm >= lm) && (dc >= lc) &&
                    (nm == 2'd0 || nm >= nc) && (rm == 2'd0 || rm >= rc);
    assign step_ready = (state_q == IDLE) && !start;
    assign accept  = step_valid && step_ready;
    assign wrap    = pace_q == 4'(STEP_DIV - 1);
    assign go_home = (state_q == IDLE) ? start : abort;
    assign apply   = (accept && legal) || (state_q == AUTO && !abort && wrap);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        c_d     = c_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pace_d  = pace_q;
        ill_d   = accept && !legal;
        if (go_home) begin
            m_d     = 2'd3;
            c_d     = 2'd3;
            dir_d   = 1'b0;
            cnt_d   = 5'd0;
            idx_d   = 4'd0;
            pace_d  = 4'd0;
            state_d = (state_q == IDLE) ? AUTO : IDLE;
        end else if (apply) begin
            m_d   = nm;
            c_d   = nc;
            dir_d = ~dir_q;
            cnt_d = cnt_q + 5'(cnt_q != 5'd31);
            // Only the final move of a solution lands everyone on the right.
            if (nm == 2'd0 && nc == 2'd0 && !dir_q) state_d = DONE;
        end
        if (state_q == AUTO && !abort) begin
            pace_d = wrap ? 4'd0 : pace_q + 4'd1;
            idx_d  = idx_q + 4'(wrap);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= 2'd3;
            c_q     <= 2'd3;
            dir_q   <= 1'b0;
            cnt_q   <= 5'd0;
            idx_q   <= 4'd0;
            pace_q  <= 4'd0;
            ill_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            c_q     <= c_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pace_q  <= pace_d;
            ill_q   <= ill_d;
            busy_q  <= state_d == AUTO;
            done_q  <= state_d == DONE;
        end
    end

    assign missionary_left = m_q;
    assign cannibal_left   = c_q;
    assign direction       = dir_q;
    assign move_cnt        = cnt_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign illegal         = ill_q;
endmodule
